game_collision_tracker: RTL and testbench
=========================================

# game_collision_tracker

Parametrised, frame-aware successor to the per-pixel collision logic. It combines the per-pixel drawing requests from the terrain, player, shot, NUM_ALIEN aliens and NUM_GOLD gold bags into registered collision signals. It accumulates sticky per-frame hit flags and turns them into one-cycle event pulses at each frame boundary. It also owns the player death/respawn state machine, the lives counter and the saturating score counter consumed by the HUD and the object controllers.

## Interface
Parameters:
- NUM_GOLD, 4: number of gold bag objects.
- NUM_ALIEN, 3: number of alien objects.
- GOLD_STATE_W, 4: width of each gold state code.
- GOLD_FALLING, 1: gold state code that kills the player or an alien on contact.
- GOLD_COLLECT, 2: gold state code in which the player may eat the gold.
- LIVES_INIT, 3: lives after reset, range 1..2^LIVES_W-1.
- LIVES_W, 3: width of the lives counter.
- SCORE_W, 16: width of the score counter.
- GOLD_POINTS, 500: points per eaten gold.
- ALIEN_POINTS, 250: points per killed alien.
- DEATH_FRAMES, 60: frames spent in DYING, minimum 1.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: synchronous, active-high reset. The name is kept for port compatibility; assertion is 1.
- startOfFrame, in, 1: one-cycle pulse at the start of each frame.
- drawing_request_terrain, in, 1: terrain pixel present.
- drawing_request_player, in, 1: player pixel present.
- shot_dr, in, 1: shot pixel present.
- alien_dr, in, NUM_ALIEN: per-alien pixel present.
- gold_dr, in, NUM_GOLD: per-gold pixel present.
- gold_state, in, NUM_GOLD*GOLD_STATE_W: gold i occupies bits [i*GOLD_STATE_W +: GOLD_STATE_W].
- player_awake, in, 1: player collisions are enabled.
- collision_player_terrain, out, 1: registered pixel-level player/terrain overlap.
- colision_fire, out, 1: registered pixel-level hit of the shot on terrain or any alien.
- collision_gold, out, NUM_GOLD: registered pixel-level hit of gold i with the player or any alien.
- player_eat_gold, out, NUM_GOLD: one-cycle frame event.
- alien_died, out, NUM_ALIEN: one-cycle frame event.
- player_died, out, 1: one-cycle frame event.
- player_dying, out, 1: high while in DYING.
- game_over, out, 1: high while in OVER.
- lives, out, LIVES_W: remaining lives.
- score, out, SCORE_W: accumulated score.

## Operation
- Pixel hits are combinational within each cycle:
  - eat_hit[i] = gold_dr[i] & drawing_request_player & (gold_state[i]==GOLD_COLLECT).
  - crush[i] = gold_dr[i] & (gold_state[i]==GOLD_FALLING).
  - alien_hit[j] = alien_dr[j] & (shot_dr | any crush).
  - death_hit = drawing_request_player & player_awake & (any alien_dr | any crush).
- Pixel-level outputs are the same expressions as the previous design, OR-reduced over channels and registered.
- Sticky flags:
  - eat_f[NUM_GOLD], kill_f[NUM_ALIEN] and death_f are set by the matching pixel hits.
  - death_f is set only in ALIVE.
  - The flags are cleared on the startOfFrame cycle.
- Frame commit happens on the startOfFrame cycle. Each event value is its flag OR the same-cycle hit.
  - In ALIVE and DYING, player_eat_gold and alien_died are driven with these events for exactly one cycle.
  - In OVER, all events are discarded and every pulse stays 0.
- Score:
  - score += GOLD_POINTS*popcount(eat) + ALIEN_POINTS*popcount(kill).
  - The sum is computed at SCORE_W+8 bits and saturates at 2^SCORE_W-1.
  - Score is frozen in OVER.
- Death FSM, evaluated only at commit:
  - ALIVE, death event, lives>1: player_died pulses, lives decrements, death counter loads DEATH_FRAMES, go to DYING.
  - ALIVE, death event, lives==1: player_died pulses, lives goes to 0, go to OVER.
  - DYING: the counter decrements each commit. Reaching 0 returns to ALIVE. Deaths are ignored. Eats and kills still score.
  - OVER: terminal until reset.
- Reset values:
  - All outputs 0, except lives=LIVES_INIT.
  - FSM in ALIVE; all flags and counters 0.
  - Reset mid-frame discards the pending flags.

## Timing
- Pixel-level outputs appear 1 cycle after their inputs (registered).
- Event pulses, lives, score and the FSM outputs update on the clock edge ending the startOfFrame cycle. They are visible in the following cycle.
- Event pulses are exactly 1 cycle wide, at most one per frame per channel.
- Simultaneous events:
  - A hit in the startOfFrame cycle is counted in the ending frame, not the next.
  - Eat and death in the same frame: score updates and the death is processed in the same commit.
- Entering DYING with DEATH_FRAMES=N means ALIVE is restored on the N-th subsequent commit.
- Back-to-back startOfFrame pulses with no hits produce no events.

## Test plan
- Reset: after resetN=1 for 1 cycle, lives=3, score=0, all pulses 0, player_dying=0, game_over=0.
- Gold 2 in state 2 overlaps the player for 10 pixels in one frame, then startOfFrame: player_eat_gold=4'b0100 for exactly 1 cycle, score=500; collision_gold[2] follows gold_dr with 1-cycle lag.
- Shot overlaps aliens 0 and 1 in the same frame: alien_died=3'b011 pulse; score increases by 500.
- Alien overlaps the awake player: player_died pulse, lives=2, player_dying=1. A repeated overlap during the next 60 frames gives no pulse. player_dying drops at the 60th commit.
- Three deaths from reset: lives=0, game_over=1. Later eats and kills produce no pulses and score is unchanged.
- SCORE_W=10, score=1000, one gold eaten: score saturates at 1023.

Source files
------------

// File: rtl/game_collision_tracker.sv
// rtl/game_collision_tracker.sv - per-pixel collision detection, per-frame events, death FSM, lives and score
module game_collision_tracker #(
    parameter int NUM_GOLD     = 4,
    parameter int NUM_ALIEN    = 3,
    parameter int GOLD_STATE_W = 4,
    parameter int GOLD_FALLING = 1,
    parameter int GOLD_COLLECT = 2,
    parameter int LIVES_INIT   = 3,
    parameter int LIVES_W      = 3,
    parameter int SCORE_W      = 16,
    parameter int GOLD_POINTS  = 500,
    parameter int ALIEN_POINTS = 250,
    parameter int DEATH_FRAMES = 60
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic                             drawing_request_terrain,
    input  logic                             drawing_request_player,
    input  logic                             shot_dr,
    input  logic [NUM_ALIEN-1:0]             alien_dr,
    input  logic [NUM_GOLD-1:0]              gold_dr,
    input  logic [NUM_GOLD*GOLD_STATE_W-1:0] gold_state,
    input  logic                             player_awake,
    output logic                             collision_player_terrain,
    output logic                             colision_fire,
    output logic [NUM_GOLD-1:0]              collision_gold,
    output logic [NUM_GOLD-1:0]              player_eat_gold,
    output logic [NUM_ALIEN-1:0]             alien_died,
    output logic                             player_died,
    output logic                             player_dying,
    output logic                             game_over,
    output logic [LIVES_W-1:0]               lives,
    output logic [SCORE_W-1:0]               score
);

    localparam int SUM_W = SCORE_W + 8;
    localparam int CNT_W = $clog2(DEATH_FRAMES + 1);

    typedef enum logic [1:0] {
        S_ALIVE = 2'd0,
        S_DYING = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t state;

    logic [NUM_GOLD-1:0]  eat_hit, crush, eat_f, eat_ev;
    logic [NUM_ALIEN-1:0] alien_hit, kill_f, kill_ev;
    logic                 any_crush, any_alien, death_hit, death_f, death_ev;
    logic [CNT_W-1:0]     death_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;

    always_comb begin
        eat_hit = '0;
        crush   = '0;
        for (int i = 0; i < NUM_GOLD; i++) begin
            eat_hit[i] = gold_dr[i] & drawing_request_player &
                         (gold_state[i*GOLD_STATE_W +: GOLD_STATE_W] == GOLD_STATE_W'(GOLD_COLLECT));
            crush[i]   = gold_dr[i] &
                         (gold_state[i*GOLD_STATE_W +: GOLD_STATE_W] == GOLD_STATE_W'(GOLD_FALLING));
        end
    end

    assign any_crush = |crush;
    assign any_alien = |alien_dr;
    assign alien_hit = alien_dr & {NUM_ALIEN{shot_dr | any_crush}};
    assign death_hit = drawing_request_player & player_awake & (any_alien | any_crush);

    // Same-cycle hits on the commit cycle still belong to the frame that is ending.
    assign eat_ev   = eat_f | eat_hit;
    assign kill_ev  = kill_f | alien_hit;
    assign death_ev = death_f | (death_hit & (state == S_ALIVE));

    always_comb begin
        score_sum = SUM_W'(score);
        for (int i = 0; i < NUM_GOLD; i++)
            if (eat_ev[i]) score_sum = score_sum + SUM_W'(GOLD_POINTS);
        for (int j = 0; j < NUM_ALIEN; j++)
            if (kill_ev[j]) score_sum = score_sum + SUM_W'(ALIEN_POINTS);
        score_next = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state                    <= S_ALIVE;
            eat_f                    <= '0;
            kill_f                   <= '0;
            death_f                  <= 1'b0;
            death_cnt                <= '0;
            collision_player_terrain <= 1'b0;
            colision_fire            <= 1'b0;
            collision_gold           <= '0;
            player_eat_gold          <= '0;
            alien_died               <= '0;
            player_died              <= 1'b0;
            player_dying             <= 1'b0;
            game_over                <= 1'b0;
            lives                    <= LIVES_W'(LIVES_INIT);
            score                    <= '0;
        end else begin
            collision_player_terrain <= drawing_request_player & drawing_request_terrain;
            colision_fire            <= shot_dr & (drawing_request_terrain | any_alien);
            collision_gold           <= gold_dr & {NUM_GOLD{drawing_request_player | any_alien}};
            player_eat_gold          <= '0;
            alien_died               <= '0;
            player_died              <= 1'b0;

            if (startOfFrame) begin
                eat_f   <= '0;
                kill_f  <= '0;
                death_f <= 1'b0;
                if (state != S_OVER) begin
                    player_eat_gold <= eat_ev;
                    alien_died      <= kill_ev;
                    score           <= score_next;
                end
                case (state)
                    S_ALIVE: begin
                        if (death_ev) begin
                            player_died <= 1'b1;
                            if (lives > LIVES_W'(1)) begin
                                lives        <= lives - LIVES_W'(1);
                                death_cnt    <= CNT_W'(DEATH_FRAMES);
                                state        <= S_DYING;
                                player_dying <= 1'b1;
                            end else begin
                                lives     <= '0;
                                state     <= S_OVER;
                                game_over <= 1'b1;
                            end
                        end
                    end
                    S_DYING: begin
                        death_cnt <= death_cnt - CNT_W'(1);
                        if (death_cnt == CNT_W'(1)) begin
                            state        <= S_ALIVE;
                            player_dying <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                eat_f  <= eat_f | eat_hit;
                kill_f <= kill_f | alien_hit;
                if (state == S_ALIVE)
                    death_f <= death_f | death_hit;
            end
        end
    end

endmodule

// File: tb/tb_game_collision_tracker.sv
// tb/tb_game_collision_tracker.sv - randomized scoreboard bench for game_collision_tracker
module tb_game_collision_tracker;

    logic        clk = 1'b0;
    logic        rst, sof, terr, pl, sh, awake;
    logic [2:0]  al;
    logic [3:0]  gd;
    logic [15:0] gs;

    logic        cpt_a, fire_a, pd_a, dying_a, over_a;
    logic [3:0]  cg_a, eat_a;
    logic [2:0]  ad_a;
    logic [2:0]  lives_a;
    logic [15:0] score_a;

    logic        cpt_b, fire_b, pd_b, dying_b, over_b;
    logic [3:0]  cg_b, eat_b;
    logic [2:0]  ad_b;
    logic [2:0]  lives_b;
    logic [9:0]  score_b;

    always #5 clk = ~clk;

    game_collision_tracker u_dut (
        .clk(clk), .resetN(rst), .startOfFrame(sof),
        .drawing_request_terrain(terr), .drawing_request_player(pl), .shot_dr(sh),
        .alien_dr(al), .gold_dr(gd), .gold_state(gs), .player_awake(awake),
        .collision_player_terrain(cpt_a), .colision_fire(fire_a), .collision_gold(cg_a),
        .player_eat_gold(eat_a), .alien_died(ad_a), .player_died(pd_a),
        .player_dying(dying_a), .game_over(over_a), .lives(lives_a), .score(score_a)
    );

    game_collision_tracker #(.SCORE_W(10)) u_sat (
        .clk(clk), .resetN(rst), .startOfFrame(sof),
        .drawing_request_terrain(terr), .drawing_request_player(pl), .shot_dr(sh),
        .alien_dr(al), .gold_dr(gd), .gold_state(gs), .player_awake(awake),
        .collision_player_terrain(cpt_b), .colision_fire(fire_b), .collision_gold(cg_b),
        .player_eat_gold(eat_b), .alien_died(ad_b), .player_died(pd_b),
        .player_dying(dying_b), .game_over(over_b), .lives(lives_b), .score(score_b)
    );

    typedef struct {
        int       due;
        bit       cpt, fire, pd, dying, over;
        bit [3:0] cg, eat;
        bit [2:0] ad;
        int       lives, score, score10;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-frame accumulated sets and plain integer counters.
    bit [3:0] eat_acc;
    bit [2:0] kill_acc;
    bit       death_acc, m_over;
    int       m_lives, m_score, m_score10, m_dying_left;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("due_cycle", e.due, cyc);
            chk("player_terrain", cpt_a, e.cpt);
            chk("fire", fire_a, e.fire);
            chk("collision_gold", cg_a, e.cg);
            chk("player_eat_gold", eat_a, e.eat);
            chk("alien_died", ad_a, e.ad);
            chk("player_died", pd_a, e.pd);
            chk("player_dying", dying_a, e.dying);
            chk("game_over", over_a, e.over);
            chk("lives", lives_a, e.lives);
            chk("score", score_a, e.score);
            chk("sat_eat", eat_b, e.eat);
            chk("sat_alien_died", ad_b, e.ad);
            chk("sat_lives", lives_b, e.lives);
            chk("sat_score", score_b, e.score10);
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic step();
        exp_t     e;
        bit [3:0] eat_h, crush, ev_eat;
        bit [2:0] kill_h, ev_kill;
        bit       death_h, alive, ev_death;
        int       add;
        e = '{default: 0};
        e.due = cyc + 1;
        if (rst) begin
            eat_acc = 0; kill_acc = 0; death_acc = 0; m_over = 0;
            m_lives = 3; m_score = 0; m_score10 = 0; m_dying_left = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                eat_h[i] = gd[i] && pl && (gs[i*4 +: 4] == 4'd2);
                crush[i] = gd[i] && (gs[i*4 +: 4] == 4'd1);
            end
            for (int j = 0; j < 3; j++)
                kill_h[j] = al[j] && (sh || crush != 0);
            death_h = pl && awake && (al != 0 || crush != 0);
            alive   = !m_over && m_dying_left == 0;
            e.cpt  = pl && terr;
            e.fire = sh && (terr || al != 0);
            for (int i = 0; i < 4; i++)
                e.cg[i] = gd[i] && (pl || al != 0);
            if (sof) begin
                ev_eat   = eat_acc | eat_h;
                ev_kill  = kill_acc | kill_h;
                ev_death = death_acc || (death_h && alive);
                if (!m_over) begin
                    e.eat = ev_eat;
                    e.ad  = ev_kill;
                    add = 500 * $countones(ev_eat) + 250 * $countones(ev_kill);
                    m_score   = sat(m_score + add, 65535);
                    m_score10 = sat(m_score10 + add, 1023);
                end
                if (alive && ev_death) begin
                    e.pd = 1;
                    m_lives--;
                    if (m_lives == 0) m_over = 1;
                    else m_dying_left = 60;
                end else if (m_dying_left > 0) begin
                    m_dying_left--;
                end
                eat_acc = 0; kill_acc = 0; death_acc = 0;
            end else begin
                eat_acc  |= eat_h;
                kill_acc |= kill_h;
                if (alive) death_acc |= death_h;
            end
        end
        e.dying   = !m_over && m_dying_left > 0;
        e.over    = m_over;
        e.lives   = m_lives;
        e.score   = m_score;
        e.score10 = m_score10;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        terr = 0; pl = 0; sh = 0; al = 0; gd = 0; gs = 0;
    endtask

    task automatic rand_inputs();
        terr = $urandom_range(0, 1);
        pl   = ($urandom_range(0, 3) == 0);
        sh   = ($urandom_range(0, 3) == 0);
        for (int j = 0; j < 3; j++) al[j] = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < 4; i++) begin
            gd[i]       = ($urandom_range(0, 5) == 0);
            gs[i*4 +: 4] = 4'($urandom_range(0, 3));
        end
    endtask

    // mode: 0 quiet, 1 random, 2 gold 2 eaten for 10 pixels, 3 shot on aliens 0/1, 4 alien on player
    task automatic run_frame(input int len, input bit awk, input int mode);
        for (int c = 0; c < len; c++) begin
            rst = 0;
            sof = (c == 0);
            awake = awk;
            clear_inputs();
            case (mode)
                1: rand_inputs();
                2: if (c >= 1 && c <= 10) begin pl = 1; gd = 4'b0100; gs = 16'h0200; end
                3: if (c == 3) begin sh = 1; al = 3'b011; end
                4: if (c == 2) begin pl = 1; al = 3'b100; end
                default: ;
            endcase
            step();
        end
    endtask

    initial begin
        rst = 1; sof = 0; awake = 0;
        clear_inputs();
        step();
        run_frame(8, 1, 0);
        run_frame(16, 1, 2);
        run_frame(6, 1, 0);
        run_frame(8, 1, 3);
        run_frame(6, 1, 0);
        run_frame(6, 1, 4);
        for (int f = 0; f < 64; f++) run_frame(6, 1, 4);
        run_frame(4, 1, 0);
        run_frame(4, 1, 0);
        for (int f = 0; f < 40; f++) run_frame($urandom_range(4, 20), 0, 1);
        for (int f = 0; f < 400 && !m_over; f++) run_frame($urandom_range(4, 20), 1, 1);
        chk("reached_game_over", m_over, 1);
        for (int f = 0; f < 20; f++) run_frame($urandom_range(4, 20), 1, 1);
        run_frame(5, 0, 1);
        rst = 1; sof = 0; clear_inputs();
        step();
        for (int f = 0; f < 10; f++) run_frame($urandom_range(4, 20), 0, 1);
        run_frame(3, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
